// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed 4-digit 7-segment driver. Snapshots BCD/DP
//               once per scan frame, so a frame is never torn. Inserts one
//               blanked select cycle at each digit change to stop ghosting.
//               Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros
//               on digits 3..1.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int SCAN_MAX = 1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] BCD,
    input  logic [3:0]  DP,
    output logic [7:0]  LED,
    output logic [3:0]  SA,
    output logic        FRAME
);

    localparam int PCNT_W = (SCAN_MAX > 2) ? $clog2(SCAN_MAX) : 1;
    localparam logic [PCNT_W-1:0] c_PCNT_LAST = PCNT_W'(SCAN_MAX - 1);
    localparam logic [PCNT_W-1:0] c_PCNT_ONE  = PCNT_W'(1);

    logic [PCNT_W-1:0] r_pcnt;
    logic [1:0]        r_idx;
    logic [15:0]       r_sh_bcd;
    logic [3:0]        r_sh_dp;
    logic              r_prime;
    logic              r_frame;
    logic [7:0]        r_led;
    logic [3:0]        r_sa;

    logic              w_last;
    logic              w_load;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg;
    logic              w_blank;

    // Segment pattern for one BCD value; 10..15 render as a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Slot timing, snapshot strobe and current digit selection.
    always_comb begin
        w_last  = (r_pcnt == c_PCNT_LAST);
        w_load  = r_prime || (w_last && (r_idx == 2'd3));
        w_digit = r_sh_bcd[r_idx*4 +: 4];
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit blanks only when it and every digit to its left hold zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd3:    w_blank = (r_sh_bcd[15:12] == 4'd0);
            2'd2:    w_blank = (r_sh_bcd[15:8]  == 8'd0);
            2'd1:    w_blank = (r_sh_bcd[15:4]  == 12'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    // Without leading-zero suppression every digit decodes normally.
    always_comb begin
        w_blank = 1'b0;
    end
`endif

    // Segment pattern for the digit being scanned.
    always_comb begin
        w_seg = w_blank ? 7'h00 : seg_decode(w_digit);
    end

    // Prescaler and digit index: advance one slot every SCAN_MAX clocks.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pcnt <= '0;
            r_idx  <= 2'd0;
        end else if (w_last) begin
            r_pcnt <= '0;
            r_idx  <= r_idx + 2'd1;
        end else begin
            r_pcnt <= r_pcnt + c_PCNT_ONE;
        end
    end

    // Shadow snapshot on the first post-reset edge and at every frame wrap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sh_bcd <= 16'h0000;
            r_sh_dp  <= 4'h0;
            r_prime  <= 1'b1;
            r_frame  <= 1'b0;
        end else begin
            if (w_load) begin
                r_sh_bcd <= BCD;
                r_sh_dp  <= DP;
            end
            r_prime <= 1'b0;
            r_frame <= w_load;
        end
    end

    // Registered display outputs; select goes dark on the last slot cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_led <= 8'h00;
            r_sa  <= 4'h0;
        end else begin
            r_led <= {r_sh_dp[r_idx], w_seg};
            r_sa  <= w_last ? 4'h0 : (4'b0001 << r_idx);
        end
    end

    assign LED   = r_led;
    assign SA    = r_sa;
    assign FRAME = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed table-driven bench for seg7_scan_driver (SCAN_MAX=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int SCAN_MAX = 4;
    localparam int NVEC     = 64;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] c_Z = 8'h00;
`else
    localparam logic [7:0] c_Z = 8'h3F;
`endif

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  sa;
        logic [7:0]  led;
        logic        frame;
    } vec_t;

    logic        CLK   = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] BCD   = 16'h0000;
    logic [3:0]  DP    = 4'h0;
    logic [7:0]  LED;
    logic [3:0]  SA;
    logic        FRAME;

    int total = 0;
    int bad   = 0;

    vec_t vec [NVEC];

    seg7_scan_driver #(.SCAN_MAX(SCAN_MAX)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .BCD   (BCD),
        .DP    (DP),
        .LED   (LED),
        .SA    (SA),
        .FRAME (FRAME)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] sa, input logic [7:0] led,
                             input logic fr);
        check({tag, ".SA"},    {4'h0, SA},    {4'h0, sa});
        check({tag, ".LED"},   LED,           led);
        check({tag, ".FRAME"}, {7'h0, FRAME}, {7'h0, fr});
    endtask

    // Fill one 4-cycle digit slot: three selected cycles then one dark cycle.
    task automatic add_slot(input int base, input logic [3:0] sa, input logic [7:0] led);
        for (int k = 0; k < 4; k++) begin
            vec[base+k].sa    = (k == 3) ? 4'h0 : sa;
            vec[base+k].led   = led;
            vec[base+k].frame = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Expected display per frame (entry i = outputs after post-reset edge i+1).
        add_slot(0,  4'h1, 8'h6F); add_slot(4,  4'h2, 8'h6D);
        add_slot(8,  4'h4, c_Z);   add_slot(12, 4'h8, c_Z);
        add_slot(16, 4'h1, 8'h3F); add_slot(20, 4'h2, 8'h7D);
        add_slot(24, 4'h4, c_Z);   add_slot(28, 4'h8, c_Z);
        add_slot(32, 4'h1, 8'h3F); add_slot(36, 4'h2, 8'h3F);
        add_slot(40, 4'h4, 8'h3F); add_slot(44, 4'h8, 8'hC0);
        add_slot(48, 4'h1, 8'h6D); add_slot(52, 4'h2, c_Z);
        add_slot(56, 4'h4, c_Z);   add_slot(60, 4'h8, c_Z);
        // First edge: prime load shows the cleared shadow (digit 0 = "0").
        vec[0].led   = 8'h3F;
        vec[0].frame = 1'b1;
        for (int i = 15; i < NVEC; i += 16) vec[i].frame = 1'b1;
        // Inputs: 0059, changed to 0060 mid digit1 slot, then A000/DP3, then 0005.
        for (int i = 0; i < NVEC; i++) begin
            vec[i].bcd = (i < 5) ? 16'h0059 : (i < 31) ? 16'h0060 :
                         (i < 47) ? 16'hA000 : 16'h0005;
            vec[i].dp  = (i >= 31 && i < 47) ? 4'b1000 : 4'b0000;
        end

        // Reset held across clock edges.
        BCD = 16'h0059;
        DP  = 4'h0;
        repeat (3) step();
        check_all("reset", 4'h0, 8'h00, 1'b0);
        #2 RESET = 1'b0;

        // Table-driven scan frames.
        for (int i = 0; i < NVEC; i++) begin
            BCD = vec[i].bcd;
            DP  = vec[i].dp;
            step();
            check_all($sformatf("vec%0d", i), vec[i].sa, vec[i].led, vec[i].frame);
        end

        // Advance into the digit2 slot of the next frame.
        repeat (10) step();
        check("pre_reset.SA", {4'h0, SA}, 8'h04);

        // Asynchronous reset between edges.
        #2 RESET = 1'b1;
        #1;
        check_all("async_rst", 4'h0, 8'h00, 1'b0);
        repeat (2) step();
        check_all("rst_hold", 4'h0, 8'h00, 1'b0);
        #2 RESET = 1'b0;

        // Restart: prime snapshot, scanning from digit0.
        step();
        check_all("restart0", 4'h1, 8'h3F, 1'b1);
        step();
        check_all("restart1", 4'h1, 8'h6D, 1'b0);
        step();
        check_all("restart2", 4'h1, 8'h6D, 1'b0);
        step();
        check_all("restart3", 4'h0, 8'h6D, 1'b0);
        step();
        check_all("restart4", 4'h2, c_Z, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
